// File: rtl/v_receiver_credit_sched.sv
// v_receiver_credit_sched: per-VC receive buffer feeding the scoreboard round-robin, one credit per consumed flit
module input_port_flit_decoder #(
  parameter int FLIT_LENGTH = 256,
  parameter int NODE_ID_W   = 4,
  parameter int TXN_ID_W    = 8,
  parameter int IO_PORT_W   = 3
) (
  input  logic [FLIT_LENGTH-1:0] flit_i,
  input  logic [IO_PORT_W-1:0]   look_ahead_routing_i,
  output logic [NODE_ID_W-1:0]   src_id_o,
  output logic [TXN_ID_W-1:0]    txn_id_o
);
  logic unused_bits;
  assign src_id_o    = flit_i[NODE_ID_W-1:0];
  assign txn_id_o    = flit_i[NODE_ID_W +: TXN_ID_W];
  assign unused_bits = ^{flit_i[FLIT_LENGTH-1:NODE_ID_W+TXN_ID_W], look_ahead_routing_i};
endmodule

module v_receiver_credit_sched #(
  parameter int FLIT_LENGTH      = 256,
  parameter int FLIT_DATA_LENGTH = 128,
  parameter int VC_NUM           = 4,
  parameter int VC_DEPTH         = 2,
  parameter int VC_ID_NUM_MAX_W  = 3,
  parameter int IO_PORT_W        = 3,
  parameter int NODE_ID_W        = 4,
  parameter int TXN_ID_W         = 8,
  localparam int INFO_W          = 2 * NODE_ID_W + TXN_ID_W + FLIT_DATA_LENGTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       rx_flit_pend_i,
  input  logic                       rx_flit_v_i,
  input  logic [FLIT_LENGTH-1:0]     rx_flit_i,
  input  logic [VC_ID_NUM_MAX_W-1:0] rx_flit_vc_id_i,
  input  logic [IO_PORT_W-1:0]       rx_flit_look_ahead_routing_i,
  output logic                       rx_lcrd_v_o,
  output logic [VC_ID_NUM_MAX_W-1:0] rx_lcrd_id_o,
  output logic                       check_scoreboard_vld_o,
  output logic [INFO_W-1:0]          check_scoreboard_o,
  input  logic                       check_scoreboard_rdy_i,
  input  logic [NODE_ID_W-1:0]       node_id_i,
  output logic                       overflow_err_o
);
  localparam int VC_W  = VC_NUM > 1 ? $clog2(VC_NUM) : 1;
  localparam int PTR_W = VC_DEPTH > 1 ? $clog2(VC_DEPTH) : 1;
  localparam int CNT_W = $clog2(VC_DEPTH + 1);
  localparam int ENT_W = FLIT_LENGTH + IO_PORT_W;

  logic [ENT_W-1:0]           mem_q [VC_NUM][VC_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q [VC_NUM], wr_ptr_d [VC_NUM];
  logic [PTR_W-1:0]           rd_ptr_q [VC_NUM], rd_ptr_d [VC_NUM];
  logic [CNT_W-1:0]           cnt_q [VC_NUM], cnt_d [VC_NUM];
  logic [VC_W-1:0]            rr_q, rr_d, gnt_q, rr_gnt, rr_idx, gnt, wr_vc;
  logic                       lock_q, lock_d, lcrd_v_q, err_q, err_d;
  logic [VC_ID_NUM_MAX_W-1:0] lcrd_id_q, lcrd_id_d;
  logic [VC_NUM-1:0]          elig;
  logic                       vld, pop, push;
  logic [ENT_W-1:0]           head;
  logic [NODE_ID_W-1:0]       src_id;
  logic [TXN_ID_W-1:0]        txn_id;
  logic                       unused_pend;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (int'(p) == VC_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Round-robin pick: first non-empty VC at or after the pointer, wrapping
  always_comb begin
    rr_gnt = rr_q;
    rr_idx = '0;
    for (int v = 0; v < VC_NUM; v++) elig[v] = cnt_q[v] != '0;
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      rr_idx = VC_W'((int'(rr_q) + i) % VC_NUM);
      if (elig[rr_idx]) rr_gnt = rr_idx;
    end
  end

  assign gnt    = lock_q ? gnt_q : rr_gnt;
  assign vld    = |elig;
  assign pop    = vld && check_scoreboard_rdy_i;
  assign wr_vc  = rx_flit_vc_id_i[VC_W-1:0];
  assign push   = rx_flit_v_i && int'(rx_flit_vc_id_i) < VC_NUM &&
                  (cnt_q[wr_vc] != CNT_W'(VC_DEPTH) || (pop && gnt == wr_vc));
  assign head   = mem_q[gnt][rd_ptr_q[gnt]];

  input_port_flit_decoder #(
    .FLIT_LENGTH(FLIT_LENGTH), .NODE_ID_W(NODE_ID_W), .TXN_ID_W(TXN_ID_W), .IO_PORT_W(IO_PORT_W)
  ) u_dec (
    .flit_i               (head[FLIT_LENGTH-1:0]),
    .look_ahead_routing_i (head[ENT_W-1:FLIT_LENGTH]),
    .src_id_o             (src_id),
    .txn_id_o             (txn_id)
  );

  // Next state for FIFO pointers/counts, RR pointer, grant lock, credit and sticky error
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      wr_ptr_d[v] = (push && wr_vc == VC_W'(v)) ? nxt(wr_ptr_q[v]) : wr_ptr_q[v];
      rd_ptr_d[v] = (pop && gnt == VC_W'(v)) ? nxt(rd_ptr_q[v]) : rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v] + CNT_W'(push && wr_vc == VC_W'(v)) - CNT_W'(pop && gnt == VC_W'(v));
    end
    rr_d      = pop ? ((int'(gnt) == VC_NUM - 1) ? '0 : gnt + 1'b1) : rr_q;
    lock_d    = vld && !check_scoreboard_rdy_i;
    lcrd_id_d = pop ? VC_ID_NUM_MAX_W'(gnt) : lcrd_id_q;
    err_d     = err_q || (rx_flit_v_i && !push);
  end

  // Flit storage; occupancy counts decide which slots are meaningful, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_vc][wr_ptr_q[wr_vc]] <= {rx_flit_look_ahead_routing_i, rx_flit_i};
  end

  // State registers; reset drops buffered flits and any credit still owed
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q  <= '{default: '0};
      rd_ptr_q  <= '{default: '0};
      cnt_q     <= '{default: '0};
      rr_q      <= '0;
      gnt_q     <= '0;
      lock_q    <= 1'b0;
      lcrd_v_q  <= 1'b0;
      lcrd_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt;
      lock_q    <= lock_d;
      lcrd_v_q  <= pop;
      lcrd_id_q <= lcrd_id_d;
      err_q     <= err_d;
    end
  end

  assign check_scoreboard_vld_o = vld;
  assign check_scoreboard_o     = {node_id_i, src_id, txn_id, head[FLIT_LENGTH-1 -: FLIT_DATA_LENGTH]};
  assign rx_lcrd_v_o            = lcrd_v_q;
  assign rx_lcrd_id_o           = lcrd_id_q;
  assign overflow_err_o         = err_q;
  assign unused_pend            = rx_flit_pend_i;
endmodule
